// File: rtl/sram_pkg.sv
// Shared types for the byte-writable SRAM with hardware clear.
// Imported by the clear sequencer and the storage top level.
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear sequencer: walks every word writing zero, then opens the
// request port. A clr pulse in any state restarts the walk at word 0.
module sram_clear_fsm
    import sram_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    output logic              init_busy,
    output logic              req_ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    sram_state_e       state;
    sram_state_e       state_nxt;
    logic [ADDR_W-1:0] init_ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = init_ptr;
        unique case (state)
            INIT: begin
                if (clr) begin
                    ptr_nxt = '0;
                end else if (init_ptr == LAST) begin
                    state_nxt = RUN;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = init_ptr + 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_nxt = INIT;
                    ptr_nxt   = '0;
                end
            end
        endcase
    end

    // Gating on resetn keeps the handshake defined before the first edge.
    always_comb begin
        init_busy = !resetn || (state == INIT);
        req_ready = resetn && (state == RUN) && !clr;
        clr_we    = resetn && (state == INIT);
        clr_addr  = init_ptr;
    end

endmodule

// File: rtl/sram_bw_init.sv
// Single-port synchronous SRAM with byte enables, valid/ready requests,
// registered reads and a zeroing sequencer after reset or clr.
module sram_bw_init
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              rd_valid,
    output logic              init_busy
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic              in_range;

    sram_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (clr),
        .init_busy (init_busy),
        .req_ready (req_ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign acc      = req_valid && req_ready;
    assign wr_acc   = acc && we;
    assign rd_acc   = acc && !we;
    assign in_range = {1'b0, add} < DEPTH_L;

    // Clear writes and accepted writes never coincide: the port is closed in INIT.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[add][i*BYTE_W +: BYTE_W] <= wd[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd       <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd <= in_range ? mem[add] : '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_bw_init.sv
// Directed bench: DEPTH=8/32-bit instance for init, byte enables, clr
// and reset; DEPTH=6/64-bit instance for random traffic vs a byte model.
module tb_sram_bw_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_resetn, a_clr, a_req_valid, a_req_ready, a_we;
    logic [3:0]  a_be;
    logic [2:0]  a_add;
    logic [31:0] a_wd, a_rd;
    logic        a_rd_valid, a_init_busy;

    logic        b_resetn, b_clr, b_req_valid, b_req_ready, b_we;
    logic [7:0]  b_be;
    logic [2:0]  b_add;
    logic [63:0] b_wd, b_rd;
    logic        b_rd_valid, b_init_busy;

    logic [63:0] model [8];

    sram_bw_init #(.DATA_W(32), .DEPTH(8)) u_a (
        .clk       (clk),
        .resetn    (a_resetn),
        .clr       (a_clr),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .we        (a_we),
        .be        (a_be),
        .add       (a_add),
        .wd        (a_wd),
        .rd        (a_rd),
        .rd_valid  (a_rd_valid),
        .init_busy (a_init_busy)
    );

    sram_bw_init #(.DATA_W(64), .DEPTH(6)) u_b (
        .clk       (clk),
        .resetn    (b_resetn),
        .clr       (b_clr),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .we        (b_we),
        .be        (b_be),
        .add       (b_add),
        .wd        (b_wd),
        .rd        (b_rd),
        .rd_valid  (b_rd_valid),
        .init_busy (b_init_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [2:0] ad, input logic [3:0] b,
                           input logic [31:0] d);
        a_req_valid = 1'b1;
        a_we        = 1'b1;
        a_add       = ad;
        a_be        = b;
        a_wd        = d;
        #1 chk("a_wr_ready", a_req_ready, 1);
        @(posedge clk);
        #1 chk("a_wr_no_rdv", a_rd_valid, 0);
        a_req_valid = 1'b0;
    endtask

    task automatic a_read(input logic [2:0] ad, input logic [31:0] exp);
        a_req_valid = 1'b1;
        a_we        = 1'b0;
        a_add       = ad;
        #1 chk("a_rd_ready", a_req_ready, 1);
        @(posedge clk);
        #1 chk("a_rd_valid", a_rd_valid, 1);
        chk("a_rd_data", a_rd, exp);
        a_req_valid = 1'b0;
    endtask

    task automatic a_init_walk();
        for (int k = 0; k < 8; k++) begin
            chk("a_init_busy", a_init_busy, 1);
            chk("a_init_ready", a_req_ready, 0);
            @(posedge clk);
            #1;
        end
        chk("a_run_ready", a_req_ready, 1);
        chk("a_run_busy", a_init_busy, 0);
    endtask

    initial begin
        a_resetn = 0; a_clr = 0; a_req_valid = 0; a_we = 0;
        a_be = '0; a_add = '0; a_wd = '0;
        b_resetn = 0; b_clr = 0; b_req_valid = 0; b_we = 0;
        b_be = '0; b_add = '0; b_wd = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", a_init_busy, 1);
        chk("rst_ready", a_req_ready, 0);
        chk("rst_rd", a_rd, 0);
        chk("rst_rdv", a_rd_valid, 0);
        a_resetn = 1'b1;
        #1 a_init_walk();

        for (int i = 0; i < 8; i++) a_read(3'(i), 32'h0);

        a_write(3'd5, 4'hF, 32'hDEADBEEF);
        a_read(3'd5, 32'hDEADBEEF);
        @(posedge clk);
        #1 chk("idle_rdv", a_rd_valid, 0);
        chk("idle_hold", a_rd, 32'hDEADBEEF);

        a_write(3'd2, 4'hF, 32'h11223344);
        a_write(3'd2, 4'b0101, 32'hAABBCCDD);
        a_read(3'd2, 32'h11BB33DD);
        a_write(3'd2, 4'h0, 32'hFFFFFFFF);
        a_read(3'd2, 32'h11BB33DD);

        // clr collides with a write during streaming traffic
        a_write(3'd1, 4'hF, 32'h00000077);
        a_clr = 1'b1; a_req_valid = 1'b1; a_we = 1'b1;
        a_add = 3'd1; a_be = 4'hF; a_wd = 32'h5;
        #1 chk("clr_ready", a_req_ready, 0);
        @(posedge clk);
        #1 a_clr = 1'b0; a_req_valid = 1'b0;
        #1 a_init_walk();
        a_read(3'd1, 32'h0);
        a_read(3'd5, 32'h0);

        // clr in INIT restarts the walk
        a_write(3'd4, 4'hF, 32'h44444444);
        a_clr = 1'b1;
        @(posedge clk);
        #1 a_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_clr = 1'b1;
        chk("restart_busy", a_init_busy, 1);
        @(posedge clk);
        #1 a_clr = 1'b0;
        #1 a_init_walk();
        a_read(3'd4, 32'h0);

        // reset lands on a read acceptance cycle
        a_write(3'd3, 4'hF, 32'h33333333);
        a_read(3'd3, 32'h33333333);
        a_req_valid = 1'b1; a_we = 1'b0; a_add = 3'd3; a_resetn = 1'b0;
        #1 chk("mid_rst_ready", a_req_ready, 0);
        @(posedge clk);
        #1 chk("mid_rst_rd", a_rd, 0);
        chk("mid_rst_rdv", a_rd_valid, 0);
        chk("mid_rst_busy", a_init_busy, 1);
        a_req_valid = 1'b0; a_resetn = 1'b1;
        #1 a_init_walk();
        a_read(3'd3, 32'h0);

        // DEPTH=6, 64-bit instance
        b_resetn = 1'b1;
        #1;
        begin
            int n;
            n = 0;
            while (!b_req_ready && n < 20) begin
                @(posedge clk);
                #1 n++;
            end
            chk("b_init_len", 64'(n), 64'd6);
        end
        for (int t = 0; t < 1000; t++) begin
            b_req_valid = 1'b1;
            b_we  = 1'($urandom_range(0, 1));
            b_add = 3'($urandom_range(0, 7));
            b_be  = 8'($urandom_range(0, 255));
            b_wd  = {$urandom, $urandom};
            @(posedge clk);
            #1;
            if (b_we) begin
                chk("b_wr_rdv", b_rd_valid, 0);
                if (b_add < 3'd6) begin
                    for (int j = 0; j < 8; j++)
                        if (b_be[j]) model[b_add][j*8 +: 8] = b_wd[j*8 +: 8];
                end
            end else begin
                chk("b_rd_valid", b_rd_valid, 1);
                chk("b_rd_data", b_rd, model[b_add]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            b_we = 1'b0;
            b_add = 3'(i);
            @(posedge clk);
            #1 chk("b_final", b_rd, model[i]);
        end
        b_req_valid = 1'b0;
        @(posedge clk);
        #1 chk("b_end_rdv", b_rd_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bw_init.md
Name: sram_bw_init

Overview:
- Parametrised single-port synchronous SRAM: successor to the fixed 8x32 flip-flop memory.
- Adds generic width and depth, per-byte write enables, a valid/ready request handshake, a registered read with a valid strobe, and a hardware clear sequencer.
- The sequencer zeroes the array after reset or on request.
- Sits between a bus/master FSM and local storage. Scoreboards model it with a one-cycle read latency.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; need not be a power of two (>=2).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- BE_W, DATA_W/8, byte-enable width; derived.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- resetn  in  1  synchronous, active-low reset.
- clr  in  1  pulse; restarts the clear sequence.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- we  in  1  1=write, 0=read; qualified by the handshake.
- be  in  BE_W  byte enables for writes; ignored on reads.
- add  in  ADDR_W  word address.
- wd  in  DATA_W  write data.
- rd  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle strobe: rd holds fresh data.
- init_busy  out  1  clear sequence in progress.

Behaviour:
- Reset is synchronous and active-low, sampled on posedge clk.
- While resetn=0: state=INIT, init_ptr=0, rd=0, rd_valid=0, init_busy=1, req_ready=0.
- Array contents are not reset directly; the INIT sequence zeroes them.
- States: INIT, RUN.
- INIT: each posedge with resetn=1 writes 0 to mem[init_ptr] and increments init_ptr.
  - On the edge that clears DEPTH-1, go to RUN and set init_busy=0.
  - The sequence takes exactly DEPTH edges; req_ready first reads 1 in the cycle after the DEPTH-th edge.
- RUN: req_ready = !clr (combinational); req_ready=0 in INIT.
- clr=1 in RUN: on the next edge go to INIT, init_ptr=0, init_busy=1. Any request in the same cycle is not accepted (clr wins).
- clr=1 while already in INIT restarts the sequence at init_ptr=0.
- Accepted write: on the same edge, for each i with be[i]=1, mem[add][8i+7:8i] <= wd[8i+7:8i]. Other bytes are unchanged. be=0 is a legal no-op.
- Accepted read: on the same edge, rd <= mem[add] and rd_valid <= 1.
  - Data is visible after that edge, i.e. one cycle after acceptance.
  - Back-to-back reads give one result per cycle.
- rd_valid=0 on every edge without an accepted read. rd holds its last value until the next accepted read or a reset.
- Read-after-write to the same address in consecutive cycles returns the new data; no bypass is needed because the write commits before the read edge.
- Out of range (add >= DEPTH, only possible when DEPTH is not a power of two):
  - Writes are dropped.
  - Reads return rd=0 with rd_valid=1.
- Reset mid-operation (resetn=0 in RUN or INIT): the next edge forces the reset values. Any in-flight rd_valid is cancelled. The clear sequence reruns fully after release.
- Inputs are don't-care when req_valid=0. Handshake signals must not be X after reset release.

Decomposition:
- Package sram_pkg: typedef enum logic {INIT, RUN} sram_state_e; localparam BYTE_W=8.
- Sub-module sram_clear_fsm: owns state, init_ptr, init_busy and req_ready. Outputs the clear-write strobe and clear address.
- Top level holds the array, the byte-masked write mux and the registered read.

Test Plan:
- Reset/init (DEPTH=8): hold resetn=0 for 3 clocks, then release.
  - init_busy=1 and req_ready=0 for exactly 8 edges, then req_ready=1.
  - Reading addresses 0..7 gives rd=0x00000000 with rd_valid=1, one cycle after each accept.
- Full write/read: write 0xDEADBEEF to add=5 with be=4'hF, then read add=5.
  - rd=0xDEADBEEF with rd_valid=1 the cycle after the read is accepted.
  - rd_valid=0 in every other cycle.
- Byte enables: write 0x11223344 to add=2 with be=F, then write 0xAABBCCDD with be=4'b0101, then read add=2 -> rd=0x11BB33DD.
- clr collision: during streaming traffic, assert clr together with a write of 0x5 to add=1.
  - req_ready=0 in that cycle and the write is not performed.
  - init_busy=1 for 8 edges; afterwards a read of add=1 returns 0.
- Mid-run reset: issue a read of add=3 and drop resetn in the acceptance cycle. After the edge: rd=0, rd_valid=0, state INIT; 8 clear edges follow release.
- Random (DEPTH=6, DATA_W=64): 1000 random requests against a byte-accurate model. Reads of add 6/7 return 0 and writes to them are dropped. Zero mismatches required.
